// File: rtl/console_pkg.sv
// Shared types and constants for the console feeding path: feeder FSM states,
// the NUL character and the default boot banner.
package console_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    CLEAR = 2'd1,
    BOOT  = 2'd2,
    RUN   = 2'd3
  } feeder_state_t;

  localparam logic [7:0] ASCII_NUL = 8'h00;

  localparam int DEFAULT_BOOT_LEN = 16;
  localparam logic [DEFAULT_BOOT_LEN*8-1:0] DEFAULT_BOOT_STR = "Hello World!1234";

endpackage

// File: rtl/char_fifo.sv
// Synchronous first-word-fall-through FIFO of 8-bit characters; head is valid
// whenever empty is low. A push while full is accepted only if a pop happens too.
module char_fifo #(
  parameter int DEPTH_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [7:0]          push_data,
  input  logic                pop,
  output logic [7:0]          head,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_BITS:0] level
);

  localparam logic [DEPTH_BITS:0] CAPACITY = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [7:0]          mem [2**DEPTH_BITS];
  logic [DEPTH_BITS:0] wr_ptr;
  logic [DEPTH_BITS:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == CAPACITY);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[DEPTH_BITS-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_BITS-1:0]] <= push_data;
  end

endmodule

// File: rtl/console_char_feeder.sv
// Drives vga_console: startup delay, clear, optional boot banner
// (CONSOLE_FEEDER_BOOT_EN), then keystrokes from a FIFO with a fixed inter-char gap.
// Handshake: console_char != 0 is a one-cycle write strobe, console_clear a
// one-cycle strobe; the console always accepts, there is no ready.
module console_char_feeder
  import console_pkg::*;
#(
  parameter int FIFO_DEPTH_BITS = 4,
  parameter int STARTUP_DELAY   = 33333333,
`ifdef CONSOLE_FEEDER_BOOT_EN
  parameter int BOOT_LEN        = DEFAULT_BOOT_LEN,
  parameter logic [BOOT_LEN*8-1:0] BOOT_STR = DEFAULT_BOOT_STR,
`endif
  parameter int CHAR_GAP        = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ascii_new,
  input  logic          key_pressed,
  input  logic [7:0]    ascii_code,
  output logic [7:0]    console_char,
  output logic          console_clear,
  output logic          busy,
  output logic          fifo_overflow,
  output feeder_state_t dbg_state
);

  localparam int CNT_W = $clog2(STARTUP_DELAY + 1);
  localparam int GAP_W = (CHAR_GAP == 0) ? 1 : $clog2(CHAR_GAP + 1);
  localparam int LVL_W = FIFO_DEPTH_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STARTUP_DELAY - 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(CHAR_GAP);

  feeder_state_t    state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [GAP_W-1:0] gap, gap_n;
  logic             emit_q, emit_n;
  logic [7:0]       char_n;
  logic             ev, ev_q, push, push_acc, pop;
  logic [7:0]       fifo_head;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level, level_n;

`ifdef CONSOLE_FEEDER_BOOT_EN
  localparam int IDX_W = $clog2(BOOT_LEN + 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(BOOT_LEN);

  logic [IDX_W-1:0]      idx, idx_n;
  logic [BOOT_LEN*8-1:0] banner_shifted;

  // Next banner character sits in the top byte once the string is shifted left.
  assign banner_shifted = BOOT_STR << {idx_n, 3'b000};
`endif

  assign dbg_state = state;
  assign ev        = ascii_new & key_pressed & (ascii_code != ASCII_NUL);
  assign push      = ev & ~ev_q;
  assign push_acc  = push & (~fifo_full | pop);
  assign level_n   = fifo_level + LVL_W'(push_acc) - LVL_W'(pop);

  char_fifo #(.DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ascii_code),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Everything below computes the values of the *next* cycle, so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    gap_n   = emit_q ? GAP_RELOAD : ((gap != '0) ? gap - 1'b1 : '0);
    emit_n  = 1'b0;
    char_n  = ASCII_NUL;
    pop     = 1'b0;
`ifdef CONSOLE_FEEDER_BOOT_EN
    idx_n   = (state == BOOT && emit_q) ? idx + 1'b1 : idx;
`endif

    case (state)
      WAIT: begin
        if (cnt == CNT_LAST) state_n = CLEAR;
        else                 cnt_n   = cnt + 1'b1;
      end
`ifdef CONSOLE_FEEDER_BOOT_EN
      CLEAR: state_n = BOOT;
      BOOT:  if (idx_n == IDX_END && gap_n == '0) state_n = RUN;
`else
      CLEAR: state_n = RUN;
`endif
      RUN:     state_n = RUN;
      default: state_n = WAIT;
    endcase

`ifdef CONSOLE_FEEDER_BOOT_EN
    if (state_n == BOOT && gap_n == '0 && idx_n != IDX_END) begin
      emit_n = 1'b1;
      char_n = banner_shifted[BOOT_LEN*8-1 -: 8];
    end
`endif
    if (state_n == RUN && gap_n == '0 && !fifo_empty) begin
      pop    = 1'b1;
      emit_n = 1'b1;
      char_n = fifo_head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT;
      cnt           <= '0;
      gap           <= '0;
      emit_q        <= 1'b0;
      ev_q          <= 1'b0;
      console_char  <= ASCII_NUL;
      console_clear <= 1'b0;
      busy          <= 1'b1;
      fifo_overflow <= 1'b0;
`ifdef CONSOLE_FEEDER_BOOT_EN
      idx           <= '0;
`endif
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      gap           <= gap_n;
      emit_q        <= emit_n;
      ev_q          <= ev;
      console_char  <= char_n;
      console_clear <= (state_n == CLEAR);
      busy          <= (state_n != RUN) || (level_n != '0);
      fifo_overflow <= fifo_overflow | (push & fifo_full & ~pop);
`ifdef CONSOLE_FEEDER_BOOT_EN
      idx           <= idx_n;
`endif
    end
  end

endmodule

// File: tb/tb_console_char_feeder.sv
// Bench for console_char_feeder with STARTUP_DELAY=4, CHAR_GAP=1; covers both
// builds of CONSOLE_FEEDER_BOOT_EN. Cycle 0 is the first cycle after reset.
module tb_console_char_feeder;
  import console_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ascii_new = 1'b0;
  logic          key_pressed = 1'b0;
  logic [7:0]    ascii_code = 8'h00;
  logic [7:0]    console_char;
  logic          console_clear;
  logic          busy;
  logic          fifo_overflow;
  feeder_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [39:0] exp_q[$];   // {cycle, character}
  logic [31:0] clr_q[$];   // cycles with console_clear high

  console_char_feeder #(.STARTUP_DELAY(4), .CHAR_GAP(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .ascii_new     (ascii_new),
    .key_pressed   (key_pressed),
    .ascii_code    (ascii_code),
    .console_char  (console_char),
    .console_clear (console_clear),
    .busy          (busy),
    .fifo_overflow (fifo_overflow),
    .dbg_state     (dbg_state)
  );

  // ---- clock / reset-relative cycle counter ----
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---- helpers ----
  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic exp_char(input int c, input logic [7:0] ch);
    exp_q.push_back({c[31:0], ch});
  endtask

  // ---- driver tasks ----
  task automatic wait_cyc(input int t);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc != t && guard < 2000);
    if (cyc != t) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc got=%0d exp=%0d", cyc, t);
    end
  endtask

  task automatic key_at(input int t, input logic [7:0] code, input logic np, input int held);
    wait_cyc(t);
    ascii_new   = 1'b1;
    key_pressed = np;
    ascii_code  = code;
    repeat (held) @(negedge clk);
    ascii_new   = 1'b0;
    key_pressed = 1'b0;
    ascii_code  = 8'h00;
  endtask

  // Called at a negedge: reset is sampled on the next posedge; returns in cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_char",     40'(console_char),  40'h0);
    check("rst_clear",    40'(console_clear), 40'h0);
    check("rst_busy",     40'(busy),          40'h1);
    check("rst_overflow", 40'(fifo_overflow), 40'h0);
    check("rst_state",    40'(dbg_state),     40'(WAIT));
    rst = 1'b0;
  endtask

  task automatic check_drained(input string name);
    check({name, "_chars_left"}, 40'(exp_q.size()), 40'h0);
    check({name, "_clears_left"}, 40'(clr_q.size()), 40'h0);
  endtask

`ifdef CONSOLE_FEEDER_BOOT_EN
  // Banner "Hello World!1234": character i appears in cycle 5 + 2*i.
  task automatic exp_banner(input int n);
    logic [127:0] b;
    b = 128'h48656c6c6f20576f726c642131323334;
    for (int i = 0; i < n; i++) exp_char(5 + 2 * i, b[127 - 8 * i -: 8]);
  endtask
`endif

  // ---- scoreboard monitor ----
  always @(negedge clk) begin
    if (console_char != 8'h00) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_char cyc=%0d got=%h exp=none", cyc, console_char);
      end else begin
        check("char_emit", {cyc[31:0], console_char}, exp_q.pop_front());
      end
    end
    if (console_clear) begin
      check("clear_with_char", 40'(console_char), 40'h0);
      if (clr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_clear cyc=%0d exp=none", cyc);
      end else begin
        check("clear_cyc", 40'(cyc), 40'(clr_q.pop_front()));
      end
    end
  end

  // ---- stimulus ----
  initial begin
`ifdef CONSOLE_FEEDER_BOOT_EN
    // Run A: startup sequence, single key held 3 cycles, rejected events.
    do_reset();
    clr_q.push_back(32'd4);
    exp_banner(16);
    wait_cyc(36);
    check("busy_c36", 40'(busy), 40'h1);
    wait_cyc(37);
    check("busy_c37", 40'(busy), 40'h0);
    exp_char(42, 8'h61);
    key_at(40, 8'h61, 1'b1, 3);
    key_at(50, 8'h62, 1'b0, 1);
    key_at(55, 8'h00, 1'b1, 1);
    wait_cyc(65);
    check("a_overflow", 40'(fifo_overflow), 40'h0);
    check_drained("run_a");

    // Run B: 20 keys during WAIT/BOOT; key 16 hits a full FIFO with no pop.
    do_reset();
    clr_q.push_back(32'd4);
    exp_banner(16);
    for (int i = 0; i < 20; i++) begin
      if (i < 16)       exp_char(37 + 2 * i, 8'(8'h41 + i));
      else if (i >= 17) exp_char(35 + 2 * i, 8'(8'h41 + i));
    end
    for (int i = 0; i < 20; i++) key_at(2 + 2 * i, 8'(8'h41 + i), 1'b1, 1);
    wait_cyc(80);
    check("b_overflow", 40'(fifo_overflow), 40'h1);
    check("b_busy",     40'(busy),          40'h0);
    check_drained("run_b");

    // Run C: reset while the banner sits at index 7, then a clean restart.
    do_reset();
    clr_q.push_back(32'd4);
    exp_banner(7);
    wait_cyc(18);
    do_reset();
    clr_q.push_back(32'd4);
    exp_banner(16);
    wait_cyc(40);
    check("c_busy", 40'(busy), 40'h0);
    check_drained("run_c");
`else
    // No banner: key queued during WAIT comes out right after CLEAR.
    do_reset();
    clr_q.push_back(32'd4);
    exp_char(5, 8'h7A);
    key_at(1, 8'h7A, 1'b1, 1);
    wait_cyc(3);
    check("busy_c3", 40'(busy), 40'h1);
    wait_cyc(5);
    check("busy_c5", 40'(busy), 40'h0);
    exp_char(12, 8'h61);
    key_at(10, 8'h61, 1'b1, 3);
    key_at(16, 8'h62, 1'b0, 1);
    key_at(18, 8'h00, 1'b1, 1);
    for (int i = 0; i < 4; i++) exp_char(22 + 2 * i, 8'(8'h31 + i));
    for (int i = 0; i < 4; i++) key_at(20 + 2 * i, 8'(8'h31 + i), 1'b1, 1);
    wait_cyc(29);
    check("nb_overflow", 40'(fifo_overflow), 40'h0);
    check_drained("run_nb");
    // A queued key is discarded by reset before it can be emitted.
    key_at(30, 8'h71, 1'b1, 1);
    do_reset();
    clr_q.push_back(32'd4);
    wait_cyc(12);
    check("nb2_busy", 40'(busy), 40'h0);
    check_drained("run_nb2");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
